// File: rtl/rr_encoder32_5.sv
// rr_encoder32_5: registered round-robin encoder.
// Turns a one-or-more-hot request vector into a binary index. The grant is
// held under a valid/ack handshake, and priority rotates after each accepted
// grant.
//
// Handshake: out/out_onehot are meaningful only while out_valid=1. Once
// out_valid rises, the grant stays frozen until the cycle in which ack=1 is
// sampled. The transfer completes on that edge. ack is ignored while
// out_valid=0.
module rr_encoder32_5 #(
   parameter int N = 32,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [N-1:0] in,
   input  logic         ack,
   output logic [W-1:0] out,
   output logic [N-1:0] out_onehot,
   output logic         out_valid,
   output logic         any_req,
   output logic         dbg_state
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t         state, state_n;
   logic [W-1:0]   ptr, ptr_n;
   logic [W-1:0]   out_n;
   logic [N-1:0]   onehot_n;
   logic           valid_n;

   logic [W-1:0]   search_ptr;
   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;
   logic [W-1:0]   offset;
   logic           hit;
   logic [W-1:0]   hit_idx;
   logic [N-1:0]   hit_onehot;

   logic           release_grant;

   assign dbg_state = state;

   // An ack in HOLD moves priority past the granted index within the same cycle.
   assign release_grant = (state == HOLD) && ack;
   assign search_ptr    = release_grant ? out + W'(1) : ptr;

   // Rotate so that the priority index lands at bit 0.
   assign doubled = {in, in} >> search_ptr;
   assign rotated = doubled[N-1:0];

   // Lowest set bit of the rotated vector; the descending loop lets the lowest index win.
   always_comb begin
      hit    = 1'b0;
      offset = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            hit    = 1'b1;
            offset = W'(i);
         end
      end
   end

   // Undo the rotation; the W-bit add wraps modulo N.
   assign hit_idx    = search_ptr + offset;
   assign hit_onehot = {{(N-1){1'b0}}, 1'b1} << hit_idx;

   // Next-state and next-grant logic.
   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      out_n    = out;
      onehot_n = out_onehot;
      valid_n  = out_valid;
      case (state)
         IDLE: begin
            valid_n  = 1'b0;
            onehot_n = '0;
            if (enable && hit) begin
               out_n    = hit_idx;
               onehot_n = hit_onehot;
               valid_n  = 1'b1;
               state_n  = HOLD;
            end
         end
         HOLD: begin
            if (ack) begin
               ptr_n = search_ptr;
               if (enable && hit) begin
                  out_n    = hit_idx;
                  onehot_n = hit_onehot;
                  valid_n  = 1'b1;
               end else begin
                  onehot_n = '0;
                  valid_n  = 1'b0;
                  state_n  = IDLE;
               end
            end
         end
         default: begin
            state_n  = IDLE;
            onehot_n = '0;
            valid_n  = 1'b0;
         end
      endcase
   end

   // State, grant and any_req registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         out        <= '0;
         out_onehot <= '0;
         out_valid  <= 1'b0;
         any_req    <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         out        <= out_n;
         out_onehot <= onehot_n;
         out_valid  <= valid_n;
         any_req    <= |in;
      end
   end

endmodule

// File: doc/rr_encoder32_5.md
# rr_encoder32_5

Registered round-robin encoder: the inverse of the register-file write-select decoders. It takes an N-bit one-or-more-hot request vector, such as pending writeback or forwarding requests keyed by register number, and returns a binary register index. The index is held stable under a valid/ack handshake. Priority rotates after each accepted grant, so no requester starves. It sits between multi-source request logic and any port that needs a single encoded register number per cycle.

## Interface
- N, 32, request vector width (power of two, ≥2)
- W, 5, index width; W = log2(N)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  permits loading a new grant; does not affect a grant already held
- in  input  N  request vector; bit i = request for index i
- ack  input  1  consumer accepts current grant; meaningful only while out_valid=1
- out  output  W  binary index of granted request
- out_onehot  output  N  one-hot of out (all zero when out_valid=0)
- out_valid  output  1  grant held and stable
- any_req  output  1  registered OR-reduction of in (sampled every cycle)

## Operation
- State: ptr[W-1:0] (highest-priority index), grant register (out, out_onehot, out_valid), FSM {IDLE, HOLD}.
- Search function: first set bit of in at index ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N wrap). It yields no hit if in == 0.
- IDLE: if enable=1 and search hits at index k, load out=k, out_onehot=1<<k, out_valid=1, go HOLD. Otherwise stay in IDLE with out_valid=0.
- HOLD: out, out_onehot, out_valid frozen regardless of in and enable until ack=1.
- HOLD with ack=1: ptr ← (out+1) mod N. The search is re-run in the same cycle with the new ptr, using the current cycle's in.
  - If enable=1 and hit k': load k', stay in HOLD, out_valid stays 1 (back-to-back grant).
  - Else: out_valid ← 0, out_onehot ← 0, out retains its last value, go IDLE.
- ack while IDLE is ignored and ptr is unchanged.
- A request bit still asserted after its own grant is acked is legal. That index now has the lowest priority.
- Requests that deassert while another index is held are simply not seen later. There is no request latching.
- Wrap: out = N-1 acked → ptr = 0.
- Reset (any time, including mid-HOLD): asynchronous clear. ptr=0, out=0, out_onehot=0, out_valid=0, any_req=0, FSM=IDLE. The first cycle after reset release behaves as IDLE.

## Timing
- All outputs registered; there is no combinational path from in, enable, or ack to any output.
- Grant latency: in/enable sampled at edge t → out_valid=1 after edge t.
- Ack: ack=1 sampled at edge t → the next grant, or out_valid=0, is visible after edge t. Sustained ack=1 with continuous requests gives one grant per cycle.
- any_req lags in by exactly one cycle, independent of FSM state and enable.
- The search is a single-cycle combinational rotate-and-priority-encode. It must close timing at the CPU clock for N=32.

## Test plan
- Reset/idle: assert reset mid-HOLD with out=7 → outputs go to 0 before the next edge. After release with in=0 and enable=1 for 5 cycles → out_valid stays 0 and any_req stays 0.
- Single grant: ptr=0, in=32'h0000_0100, enable=1 → one cycle later out=8, out_onehot=32'h0000_0100, out_valid=1. With in changed to 32'h1 and ack=0 for 3 cycles → out stays 8. Ack with enable=0 → out_valid=0 next cycle, and the following grant from in=32'h1 after enable=1 is out=0 (wrap search from ptr=9).
- Round-robin fairness: in=32'h8000_0011 constant, enable=1, ack=1 every cycle → out sequence 0, 4, 31, 0, 4, 31 with out_valid held at 1 throughout.
- Wrap boundary: grant out=31 acked, in=32'h8000_0001 → next out=0 (ptr=0), then 31.
- Enable gating: in=32'hFF, enable=0 → no grant for 4 cycles while any_req=1 after one cycle. enable=1 → out=0 one cycle later.
- Spurious ack: ack=1 while IDLE with in=0, then in=32'h4 → out=2, confirming ptr was unchanged by the spurious ack.
